addsub_bcd_conv: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the 4-bit parallel adder/subtractor. It accepts the 5-bit result magnitude and a negative flag over a valid/ready handshake. It converts the magnitude to packed BCD with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It presents the digits and the sign for the display/readout stage over a second valid/ready handshake.

---
 rtl/addsub_bcd_conv.sv | 102 ++++++++++
 tb/tb_addsub_bcd_conv.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) placed
// after the adder/subtractor; valid/ready handshakes on both input and output.
module addsub_bcd_conv #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_mag,
    input  logic                  in_neg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BW-1:0]       acc_q, acc_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sign_q, sign_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] shifted;

    // Add-3 correction on every digit >= 5, then one left shift of {BCD, binary}.
    always_comb begin
        adj = acc_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_mag;
                    sign_d  = in_neg && (in_mag != '0);
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, bin_d} = shifted;
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[BW+WIDTH-1:WIDTH];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
    assign sign_out  = sign_q;

endmodule

// File: tb/tb_addsub_bcd_conv.sv
// Scoreboard bench for addsub_bcd_conv: driver pushes decimal-reference results,
// a monitor pops and compares on each output handshake and checks latency.
module tb_addsub_bcd_conv;

    localparam int unsigned W = 5;
    localparam int unsigned D = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_mag = '0;
    logic           in_neg = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [4*D-1:0] bcd_out;
    logic           sign_out;

    int             n_chk = 0;
    int             n_fail = 0;
    int             cyc = 0;
    logic [4*D:0]   exp_q[$];
    int             acc_q[$];
    bit             stall_mode = 1'b0;
    bit             force_ready = 1'b1;

    addsub_bcd_conv #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .in_neg(in_neg),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .sign_out(sign_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, sign suppressed for zero.
    function automatic logic [4*D:0] model(input int m, input bit n);
        logic [4*D-1:0] b;
        int v;
        b = '0;
        v = m;
        for (int d = 0; d < D; d++) begin
            b[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {n && (m != 0), b};
    endfunction

    always @(negedge clk) begin
        #1;
        out_ready = stall_mode ? ($urandom_range(0, 3) != 0) : force_ready;
    end

    // Monitor
    bit             pv = 1'b0, pr = 1'b0, ps = 1'b0;
    logic [4*D-1:0] pb = '0;
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (out_valid && !pv) begin
                if (acc_q.size() == 0) check("unexpected_output", 32'(bcd_out), 32'hFFFF);
                else check("latency", 32'(cyc), 32'(acc_q.pop_front() + W));
            end
            if (out_valid && pv && !pr) begin
                check("hold_bcd", 32'(bcd_out), 32'(pb));
                check("hold_sign", 32'(sign_out), 32'(ps));
            end
            if (out_valid) check("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_pop", 32'(bcd_out), 32'hFFFF);
                else begin
                    logic [4*D:0] e;
                    e = exp_q.pop_front();
                    check("bcd", 32'(bcd_out), 32'(e[4*D-1:0]));
                    check("sign", 32'(sign_out), 32'(e[4*D]));
                end
            end
        end
        pv = out_valid; pr = out_ready; pb = bcd_out; ps = sign_out;
    end

    task automatic send(input int m, input bit n);
        bit done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mag   = W'(m);
        in_neg   = n;
        for (int k = 0; k < 200 && !done; k++) begin
            if (in_ready) begin
                exp_q.push_back(model(m, n));
                acc_q.push_back(cyc + 1);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            check("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            #4;
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_sign", 32'(sign_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed operands, no backpressure
        force_ready = 1'b1;
        send(0, 0); send(13, 0); send(30, 0); send(31, 0); send(7, 1); send(0, 1);
        drain();

        // Backpressure with a competing input held valid
        force_ready = 1'b0;
        send(19, 0);
        for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_mag   = W'(5);
            in_neg   = 1'b0;
            #3;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_bcd", 32'(bcd_out), 32'h19);
        end
        force_ready = 1'b1;
        send(5, 0);
        drain();

        // Reset during the third shift of an operand
        send(22, 1);
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #3;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        check("abort_sign", 32'(sign_out), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        send(9, 0);
        drain();

        // Full sweep with random sign and random output stalls
        stall_mode = 1'b1;
        for (int m = 0; m < 32; m++) send(m, 1'($urandom_range(0, 1)));
        drain();
        stall_mode = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
